seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Sequential shift-add unsigned multiplier. It is the responder for the ALU's MUL/MLA/MLS requests.
- The ALU drives sign-corrected magnitudes on mul1/mul2 during exec1; this block returns the 32-bit magnitude product on mulresult, which the ALU samples in exec2.
- A start/busy/done handshake lets the state machine hold exec2 until the product is valid.
- It replaces the combinational megafunction multiplier to cut area and critical path.

Parameters:
- WIDTH, 16, operand width in bits. Product width is 2*WIDTH.
- CNT_W, 5, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active high.
- start  input  1  request a multiply. Sampled on the rising edge.
- mul1  input  WIDTH  multiplicand (unsigned magnitude from the ALU).
- mul2  input  WIDTH  multiplier (unsigned magnitude from the ALU).
- busy  output  1  high while an operation is in progress (RUN state).
- done  output  1  one-cycle pulse: mulresult valid and newly updated.
- mulresult  output  2*WIDTH  registered product. Holds its value until the next completion.

Behaviour:
- Reset (asynchronous, active high):
  - State is IDLE.
  - busy=0, done=0, mulresult=0.
  - Internal accumulator, operand shift registers and counter are all 0.
  - Reset asserted mid-operation aborts immediately; no partial result reaches mulresult.
- States:
  - IDLE: start=1 captures mul1 into the multiplicand register (zero-extended to 2*WIDTH), mul2 into the multiplier shift register, clears the accumulator and counter, and goes to RUN. start=0 stays in IDLE.
  - RUN (busy=1), on each edge:
    - If multiplier[0]=1, accumulator += multiplicand (2*WIDTH-bit add, no overflow possible).
    - Multiplicand shifts left 1. Multiplier shifts right 1 (logical). Counter +1.
    - On the edge where the counter reaches WIDTH-1 (the WIDTH-th iteration), the final accumulator value (including this iteration's add) is written to mulresult and the state goes to DONE.
  - DONE (done=1, busy=0) lasts exactly one cycle.
    - start=1 in DONE is accepted as in IDLE (back-to-back), going to RUN.
    - Otherwise the state goes to IDLE.
- Latency: start captured at edge k, done high during the cycle after edge k+WIDTH, i.e. WIDTH+1 edges including capture. Default WIDTH=16 gives 17 cycles.
- start while in RUN is ignored. Operands are not re-sampled, and mul1/mul2 may change freely after capture.
- mulresult changes only on entry to DONE or on reset. It stays stable through IDLE, so the ALU can sample it any time after done.
- Edge operands:
  - mul1=0 or mul2=0 gives product 0 with full latency.
  - mul1=mul2=2^WIDTH-1 gives 2^(2*WIDTH) - 2^(WIDTH+1) + 1 with no truncation.
- done never asserts without a preceding accepted start.

Optional Feature:
- Macro: SEQ_MULTIPLIER_EARLY_TERM_EN.
- Defined: in RUN, if the multiplier shift register is already 0 at the start of a cycle, the next edge writes the accumulator to mulresult and enters DONE without adding, regardless of the counter.
  - mul2=0 gives done after 2 edges including capture.
  - mul2=1 gives done after 3 edges.
  - Latency is (index of highest set bit of mul2) + 3 edges, capped at WIDTH+1.
- Undefined: fixed latency WIDTH+1 for all operands.
- Product values are identical in both builds.

Test Plan:
- Reset check: rst=1 then release -> busy=0, done=0, mulresult=0. Assert rst at RUN cycle 5 of a 0x1234*0x5678 operation -> IDLE, mulresult stays 0, no done pulse.
- Basic multiply: mul1=3, mul2=5, start pulse -> done exactly 1 cycle wide, 17 edges after capture; mulresult=15. Busy high for 16 cycles in between.
- Max operands: mul1=mul2=0xFFFF -> mulresult=0xFFFE0001. Then 0x8000*0x0002 -> 0x00010000.
- Handshake: start held high through RUN with operands changed to 7,7 after capture of 0x0010*0x0010 -> result 0x00000100, ignoring 7,7. start=1 during DONE with 7,7 -> second done gives 0x00000031, with mulresult holding 0x100 until then.
- Zero operand: mul1=0xABCD, mul2=0 -> result 0. Latency is 17 edges without the macro, 2 with SEQ_MULTIPLIER_EARLY_TERM_EN.
- Random regression: 1000 random operand pairs with random start gaps, compared against a reference product -> all match; no done without start; mulresult stable between done pulses.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier: unsigned shift-add multiplier, one multiplier bit per clock.
// Define SEQ_MULTIPLIER_EARLY_TERM_EN to finish as soon as no multiplier bits remain.
module seq_multiplier #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mul1,
  input  logic [WIDTH-1:0]   mul2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] mulresult
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_result;
  logic [WIDTH-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;

  logic [2*WIDTH-1:0] w_sum;
  logic               w_last;

  assign w_sum = r_mplier[0] ? r_acc + r_mcand : r_acc;

`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
  // With no set bits left, w_sum equals r_acc, so finishing now is exact.
  logic w_zero;
  assign w_zero = (r_mplier == '0);
  assign w_last = w_zero || (r_cnt == LAST);
`else
  assign w_last = (r_cnt == LAST);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_result <= w_sum;
            r_state  <= S_DONE;
          end
        end
        default: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, mul1};
            r_mplier <= mul2;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end else begin
            r_state  <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign mulresult = r_result;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed and random checks of seq_multiplier
// against a cycle-level product/latency model.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] mul1 = '0;
  logic [15:0] mul2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] mulresult;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  seq_multiplier #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mul1(mul1),
    .mul2(mul2),
    .busy(busy),
    .done(done),
    .mulresult(mulresult)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Edges from capture (inclusive) to the cycle where done is high.
  function automatic int lat_of(input logic [15:0] b);
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    int h;
    if (b == 0) return 2;
    h = 0;
    for (int i = 0; i < 16; i++) if (b[i]) h = i;
    return (h + 3 > 17) ? 17 : h + 3;
`else
    return 17;
`endif
  endfunction

  // Model: edges left before done, pending product, published result.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [31:0] m_pend = '0;
  logic [31:0] m_res  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_pend = '0;
      m_res  = '0;
    end else begin
      bit idle_now;
      idle_now = (m_left == 0);
      m_done   = 1'b0;
      if (!idle_now) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_res  = m_pend;
        end
      end else if (start) begin
        m_pend = 32'(mul1) * 32'(mul2);
        m_left = lat_of(mul2) - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("cyc_busy", 64'(busy), 64'(m_left > 0));
      chk("cyc_done", 64'(done), 64'(m_done));
      chk("cyc_result", 64'(mulresult), 64'(m_res));
    end
  end

  // Launch at a negedge; returns edges seen until done, bounded.
  task automatic launch_wait(input logic [15:0] a, input logic [15:0] b,
                             input bit keep_start, output int n,
                             output int nbusy);
    start = 1'b1;
    mul1  = a;
    mul2  = b;
    @(negedge clk);
    if (!keep_start) start = 1'b0;
    n = 1;
    nbusy = 0;
    while (!done && n < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 64'(n), 64'(0));
  endtask

  task automatic op(input string name, input logic [15:0] a,
                    input logic [15:0] b, input logic [31:0] exp,
                    input int exp_lat);
    int n, nb;
    launch_wait(a, b, 1'b0, n, nb);
    chk({name, "_lat"}, 64'(n), 64'(exp_lat));
    chk({name, "_res"}, 64'(mulresult), 64'(exp));
    @(negedge clk);
    chk({name, "_done1"}, 64'(done), 64'(0));
  endtask

  initial begin
    int n, nb;
    int ndone;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_res", 64'(mulresult), 64'(0));
    cmp_en = 1'b1;

    // Abort at RUN cycle 5.
    start = 1'b1;
    mul1  = 16'h1234;
    mul2  = 16'h5678;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_done", 64'(ndone), 64'(0));
    chk("abort_res", 64'(mulresult), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));

    // 3*5 with busy width.
    launch_wait(16'd3, 16'd5, 1'b0, n, nb);
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    chk("basic_lat", 64'(n), 64'(5));
    chk("basic_busy", 64'(nb), 64'(4));
`else
    chk("basic_lat", 64'(n), 64'(17));
    chk("basic_busy", 64'(nb), 64'(16));
`endif
    chk("basic_res", 64'(mulresult), 64'(15));
    @(negedge clk);
    chk("basic_done1", 64'(done), 64'(0));
    chk("basic_hold", 64'(mulresult), 64'(15));

    op("max", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 17);
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    op("msb", 16'h8000, 16'h0002, 32'h00010000, 4);
    op("zero", 16'hABCD, 16'h0000, 32'h0, 2);
`else
    op("msb", 16'h8000, 16'h0002, 32'h00010000, 17);
    op("zero", 16'hABCD, 16'h0000, 32'h0, 17);
`endif

    // start held through RUN with changed operands, then back-to-back.
    start = 1'b1;
    mul1  = 16'h0010;
    mul2  = 16'h0010;
    @(negedge clk);
    mul1 = 16'd7;
    mul2 = 16'd7;
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hs_res1", 64'(mulresult), 64'h100);
    chk("hs_done1", 64'(done), 64'(1));
    @(negedge clk);
    start = 1'b0;
    chk("hs_busy2", 64'(busy), 64'(1));
    chk("hs_hold", 64'(mulresult), 64'h100);
    n = 1;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hs_res2", 64'(mulresult), 64'h31);
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    chk("hs_lat2", 64'(n), 64'(5));
`else
    chk("hs_lat2", 64'(n), 64'(17));
`endif
    @(negedge clk);

    // Random operands and gaps; gap 0 restarts from DONE.
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a, b;
      int gap;
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 17 == 0) b = 16'(1 << (i % 16));
      launch_wait(a, b, 1'b0, n, nb);
      chk("rand_lat", 64'(n), 64'(lat_of(b)));
      chk("rand_res", 64'(mulresult), 64'(32'(a) * 32'(b)));
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
